// File: rtl/alu_addsub_stage_if.sv
// Bundle for the add/sub execute stage: upstream op handshake, adder drive/return
// and downstream result handshake. Signal names are seen from the stage's side.
interface alu_addsub_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) ();
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [TAG_W-1:0] tag_i;

  logic [WIDTH-1:0] add_a_o;
  logic [WIDTH-1:0] add_b_o;
  logic             add_cin_o;
  logic [WIDTH-1:0] add_sum_i;
  logic             add_cout_i;
  logic             add_ovf_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             flag_o;
  logic             err_o;
  logic [TAG_W-1:0] tag_o;

  // Stage view
  modport slave (
    input  in_valid_i, op_i, a_i, b_i, tag_i,
    input  add_sum_i, add_cout_i, add_ovf_i,
    input  out_ready_i,
    output in_ready_o,
    output add_a_o, add_b_o, add_cin_o,
    output out_valid_o, result_o, flag_o, err_o, tag_o
  );

  // Environment view (upstream source, adder, downstream sink)
  modport master (
    output in_valid_i, op_i, a_i, b_i, tag_i,
    output add_sum_i, add_cout_i, add_ovf_i,
    output out_ready_i,
    input  in_ready_o,
    input  add_a_o, add_b_o, add_cin_o,
    input  out_valid_o, result_o, flag_o, err_o, tag_o
  );
endinterface

// File: rtl/alu_addsub_stage.sv
// Two-stage execute stage that owns the external adder: S1 registers the op and drives
// the adder, S2 registers result/flag/err for writeback and branch resolution.
module alu_addsub_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_addsub_stage_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLT  = 4'd2,
    OP_SLTU = 4'd3,
    OP_BEQ  = 4'd4,
    OP_BNE  = 4'd5,
    OP_BLT  = 4'd6,
    OP_BGE  = 4'd7,
    OP_BLTU = 4'd8,
    OP_BGEU = 4'd9
  } op_e;

  localparam logic [3:0] OP_LAST = 4'd9;

  // S1 state
  logic             v1_q,   v1_d;
  logic [3:0]       op1_q,  op1_d;
  logic [WIDTH-1:0] a1_q,   a1_d;
  logic [WIDTH-1:0] b1_q,   b1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // S2 state
  logic             v2_q,   v2_d;
  logic [WIDTH-1:0] res_q,  res_d;
  logic             flag_q, flag_d;
  logic             err_q,  err_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic             s2_free;
  logic             s1_adv;
  logic             in_ready;
  logic             accept;
  logic             legal;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;

  logic             eq;
  logic             ltu;
  logic             lt;
  logic [WIDTH-1:0] res_c;
  logic             flag_c;
  logic             err_c;

  // Handshake: S2 can take a new entry when empty or draining this cycle
  always_comb begin : handshake
    s2_free  = !v2_q || bus.out_ready_i;
    s1_adv   = v1_q && s2_free;
    in_ready = !v1_q || s1_adv;
    accept   = bus.in_valid_i && in_ready;
  end

  assign legal = (op1_q <= OP_LAST);

  always_comb begin : s1_next
    v1_d   = v1_q;
    op1_d  = op1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    tag1_d = tag1_q;
    if (accept) begin
      v1_d   = 1'b1;
      op1_d  = bus.op_i;
      a1_d   = bus.a_i;
      b1_d   = bus.b_i;
      tag1_d = bus.tag_i;
    end else if (s1_adv) begin
      v1_d   = 1'b0;
    end
  end

  // Adder operands: subtract/compare as a + ~b + 1; quiet when idle or illegal
  always_comb begin : adder_drive
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (v1_q && legal) begin
      add_a = a1_q;
      if (op_e'(op1_q) == OP_ADD) begin
        add_b   = b1_q;
        add_cin = 1'b0;
      end else begin
        add_b   = ~b1_q;
        add_cin = 1'b1;
      end
    end
  end

  always_comb begin : cmp_flags
    eq  = (bus.add_sum_i == '0);
    ltu = !bus.add_cout_i;
    lt  = bus.add_sum_i[WIDTH-1] ^ bus.add_ovf_i;
  end

  always_comb begin : result_sel
    res_c  = '0;
    flag_c = 1'b0;
    err_c  = 1'b0;
    case (op_e'(op1_q))
      OP_ADD, OP_SUB: begin
        res_c  = bus.add_sum_i;
        flag_c = bus.add_cout_i;
      end
      OP_SLT: begin
        res_c  = WIDTH'(lt);
        flag_c = lt;
      end
      OP_SLTU: begin
        res_c  = WIDTH'(ltu);
        flag_c = ltu;
      end
      OP_BEQ: begin
        res_c  = bus.add_sum_i;
        flag_c = eq;
      end
      OP_BNE: begin
        res_c  = bus.add_sum_i;
        flag_c = !eq;
      end
      OP_BLT: begin
        res_c  = bus.add_sum_i;
        flag_c = lt;
      end
      OP_BGE: begin
        res_c  = bus.add_sum_i;
        flag_c = !lt;
      end
      OP_BLTU: begin
        res_c  = bus.add_sum_i;
        flag_c = ltu;
      end
      OP_BGEU: begin
        res_c  = bus.add_sum_i;
        flag_c = !ltu;
      end
      default: begin
        res_c  = '0;
        flag_c = 1'b0;
        err_c  = 1'b1;
      end
    endcase
  end

  always_comb begin : s2_next
    v2_d   = v2_q;
    res_d  = res_q;
    flag_d = flag_q;
    err_d  = err_q;
    tag2_d = tag2_q;
    if (s1_adv) begin
      v2_d   = 1'b1;
      res_d  = res_c;
      flag_d = flag_c;
      err_d  = err_c;
      tag2_d = tag1_q;
    end else if (bus.out_ready_i) begin
      v2_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin : state_regs
    if (rst_i) begin
      v1_q   <= 1'b0;
      op1_q  <= '0;
      a1_q   <= '0;
      b1_q   <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      res_q  <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
      tag2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      op1_q  <= op1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      res_q  <= res_d;
      flag_q <= flag_d;
      err_q  <= err_d;
      tag2_q <= tag2_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.add_a_o     = add_a;
  assign bus.add_b_o     = add_b;
  assign bus.add_cin_o   = add_cin;
  assign bus.out_valid_o = v2_q;
  assign bus.result_o    = res_q;
  assign bus.flag_o      = flag_q;
  assign bus.err_o       = err_q;
  assign bus.tag_o       = tag2_q;

endmodule
